// File: rtl/apb_reg_responder_pkg.sv
// rtl/apb_reg_responder_pkg.sv - shared types and constants for the APB register responder
package apb_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int APB_WORD_BYTES = 4;
    localparam int APB_WORD_SHIFT = 2;

endpackage

// File: rtl/apb_reg_responder_if.sv
// rtl/apb_reg_responder_if.sv - APB bus bundle between master transactor and completer
interface apb_reg_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, paddr, pwdata, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwdata, pwrite,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_responder_addr_decode.sv
// rtl/apb_reg_responder_addr_decode.sv - byte address to register index decode with error detection
module apb_addr_decode
    import apb_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter int                    IDX_W      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    output logic [IDX_W-1:0]      index,
    output logic                  err
);
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  below_base;
    logic                  misaligned;
    logic                  in_range;
    logic                  ro_hit;

    always_comb begin
        off        = paddr - BASE_ADDR;
        idx_full   = off >> APB_WORD_SHIFT;
        below_base = paddr < BASE_ADDR;
        misaligned = (off & ADDR_WIDTH'(APB_WORD_BYTES - 1)) != '0;
        in_range   = idx_full < ADDR_WIDTH'(NUM_REGS);
        index      = idx_full[IDX_W-1:0];
        // RO lookup only meaningful once the index is known to be in range
        ro_hit     = pwrite && in_range && RO_MASK[index];
        err        = below_base || misaligned || !in_range || ro_hit;
    end
endmodule

// File: rtl/apb_reg_responder.sv
// rtl/apb_reg_responder.sv - APB completer with wait-state insertion, error responses and a flat register bank
module apb_reg_responder
    import apb_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    apb_reg_responder_if.slave             apb,
    input  logic [3:0]                     wait_cycles,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic                           proto_err
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_write;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  proto_err_q;

    logic                  do_setup;
    logic                  do_dec;
    logic                  do_complete;
    logic                  set_proto;
    logic [IDX_W-1:0]      dec_index;
    logic                  dec_err;
    logic                  good_write;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .BASE_ADDR  (BASE_ADDR),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .paddr  (cap_addr),
        .pwrite (cap_write),
        .index  (dec_index),
        .err    (dec_err)
    );

    always_comb begin
        state_d     = state_q;
        do_setup    = 1'b0;
        do_dec      = 1'b0;
        do_complete = 1'b0;
        set_proto   = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    do_setup = 1'b1;
                    state_d  = WAIT;
                end else if (apb.psel && apb.penable) begin
                    set_proto = 1'b1;
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (!apb.penable) begin
                    // a fresh setup while waiting: restart on the new address
                    do_setup  = 1'b1;
                    set_proto = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    do_dec = 1'b1;
                end else begin
                    do_complete = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign good_write = do_complete && !dec_err && cap_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            cap_addr    <= '0;
            cap_write   <= 1'b0;
            cap_wdata   <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            wr_pulse_q  <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pready_q  <= do_complete;
            pslverr_q <= do_complete && dec_err;
            prdata_q  <= (do_complete && !dec_err && !cap_write) ? regs[dec_index] : '0;
            if (set_proto) begin
                proto_err_q <= 1'b1;
            end
            if (do_setup) begin
                cap_addr  <= apb.paddr;
                cap_write <= apb.pwrite;
                cap_wdata <= apb.pwdata;
                cnt_q     <= wait_cycles;
            end else if (do_dec) begin
                cnt_q <= cnt_q - 4'd1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse_q[i] <= good_write && (dec_index == IDX_W'(i));
            end
            if (good_write) begin
                regs[dec_index] <= cap_wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign wr_pulse    = wr_pulse_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_apb_reg_responder.sv
// tb/tb_apb_reg_responder.sv - directed vector bench for apb_reg_responder
module tb_apb_reg_responder;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   wait_cycles;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse;
    logic         proto_err;

    int passed = 0;
    int total  = 0;

    apb_reg_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_reg_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .BASE_ADDR  (32'h0),
        .RO_MASK    (16'h0001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .apb         (bus),
        .wait_cycles (wait_cycles),
        .reg_q       (reg_q),
        .wr_pulse    (wr_pulse),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wc;
        logic [3:0]  wc_mid;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [15:0] exp_pulse;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] wc, input logic [3:0] wc_mid, input logic exp_err,
                                input logic [31:0] exp_rd, input int exp_lat, input logic [15:0] exp_pulse);
        vec_t v;
        v.addr = addr; v.wr = wr; v.wdata = wdata; v.wc = wc; v.wc_mid = wc_mid;
        v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_pulse = exp_pulse;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] wc, input logic [3:0] wc_mid,
                        output logic [31:0] rd, output logic err, output int lat, output logic [15:0] pulse);
        rd = '0; err = 1'b0; lat = 0; pulse = '0;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr; bus.pwrite = wr;
        bus.pwdata = wdata; wait_cycles = wc;
        @(posedge clk); #1;
        bus.penable = 1'b1; wait_cycles = wc_mid;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.pready) begin
                lat = c; rd = bus.prdata; err = bus.pslverr; pulse = wr_pulse;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic         err;
        int           lat;
        logic [15:0]  pulse;
        logic [511:0] exp_q;
        logic         saw_ready;
        logic [15:0]  any_pulse;

        vecs[0]  = mk(32'h08,  1'b1, 32'hDEADBEEF, 4'd0, 4'd0, 1'b0, 32'h0,        2, 16'h0004);
        vecs[1]  = mk(32'h08,  1'b0, 32'h0,        4'd0, 4'd0, 1'b0, 32'hDEADBEEF, 2, 16'h0000);
        vecs[2]  = mk(32'h00,  1'b0, 32'h0,        4'd5, 4'd0, 1'b0, 32'h0,        7, 16'h0000);
        vecs[3]  = mk(32'h40,  1'b1, 32'hCAFEF00D, 4'd0, 4'd0, 1'b1, 32'h0,        2, 16'h0000);
        vecs[4]  = mk(32'h06,  1'b0, 32'h0,        4'd0, 4'd0, 1'b1, 32'h0,        2, 16'h0000);
        vecs[5]  = mk(32'h0A,  1'b0, 32'h0,        4'd0, 4'd0, 1'b1, 32'h0,        2, 16'h0000);
        vecs[6]  = mk(32'h00,  1'b1, 32'h1234,     4'd0, 4'd0, 1'b1, 32'h0,        2, 16'h0000);
        vecs[7]  = mk(32'h00,  1'b0, 32'h0,        4'd0, 4'd0, 1'b0, 32'h0,        2, 16'h0000);
        vecs[8]  = mk(32'h3C,  1'b1, 32'hA5A50F0F, 4'd2, 4'd0, 1'b0, 32'h0,        4, 16'h8000);
        vecs[9]  = mk(32'h3C,  1'b0, 32'h0,        4'd1, 4'd7, 1'b0, 32'hA5A50F0F, 3, 16'h0000);
        vecs[10] = mk(32'h04,  1'b1, 32'h11111111, 4'd0, 4'd0, 1'b0, 32'h0,        2, 16'h0002);
        vecs[11] = mk(32'h04,  1'b0, 32'h0,        4'd0, 4'd0, 1'b0, 32'h11111111, 2, 16'h0000);
        vecs[12] = mk(32'h100, 1'b0, 32'h0,        4'd0, 4'd0, 1'b1, 32'h0,        2, 16'h0000);

        reset = 1'b1; wait_cycles = 4'd0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_pready", {511'b0, bus.pready}, 512'd0);
        chk("reset_prdata", {480'b0, bus.prdata}, 512'd0);
        chk("reset_pslverr", {511'b0, bus.pslverr}, 512'd0);
        chk("reset_wr_pulse", {496'b0, wr_pulse}, 512'd0);
        chk("reset_proto_err", {511'b0, proto_err}, 512'd0);
        chk("reset_reg_q", reg_q, 512'd0);

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].wc, vecs[i].wc_mid, rd, err, lat, pulse);
            chk($sformatf("v%0d_latency", i), 512'(lat), 512'(vecs[i].exp_lat));
            chk($sformatf("v%0d_pslverr", i), {511'b0, err}, {511'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_wr_pulse", i), {496'b0, pulse}, {496'b0, vecs[i].exp_pulse});
            if (!vecs[i].wr)
                chk($sformatf("v%0d_prdata", i), {480'b0, rd}, {480'b0, vecs[i].exp_rd});
            @(negedge clk);
            chk($sformatf("v%0d_pready_drop", i), {511'b0, bus.pready}, 512'd0);
            chk($sformatf("v%0d_pulse_drop", i), {496'b0, wr_pulse}, 512'd0);
            if (i == 1)
                chk("reg2_after_write", {480'b0, reg_q[95:64]}, {480'b0, 32'hDEADBEEF});
        end

        exp_q = '0;
        exp_q[1*32 +: 32]  = 32'h11111111;
        exp_q[2*32 +: 32]  = 32'hDEADBEEF;
        exp_q[15*32 +: 32] = 32'hA5A50F0F;
        chk("reg_q_after_table", reg_q, exp_q);

        // master abort in WAIT of a write to reg 1
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h04; bus.pwrite = 1'b1;
        bus.pwdata = 32'h99; wait_cycles = 4'd3;
        @(posedge clk); #1 bus.penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
        saw_ready = 1'b0; any_pulse = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            saw_ready = saw_ready | bus.pready;
            any_pulse = any_pulse | wr_pulse;
            @(posedge clk); #1;
        end
        chk("abort_no_pready", {511'b0, saw_ready}, 512'd0);
        chk("abort_no_pulse", {496'b0, any_pulse}, 512'd0);
        chk("abort_reg1_kept", {480'b0, reg_q[63:32]}, {480'b0, 32'h11111111});
        chk("abort_no_proto_err", {511'b0, proto_err}, 512'd0);

        // access phase from IDLE without a setup
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h0; bus.pwrite = 1'b0;
        @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        chk("stray_proto_err", {511'b0, proto_err}, 512'd1);
        chk("stray_no_pready", {511'b0, bus.pready}, 512'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("proto_err_sticky", {511'b0, proto_err}, 512'd1);

        xfer(32'h0C, 1'b1, 32'h55, 4'd0, 4'd0, rd, err, lat, pulse);
        chk("reg3_write_pulse", {496'b0, pulse}, {496'b0, 16'h0008});
        chk("reg3_is_55", {480'b0, reg_q[127:96]}, {480'b0, 32'h55});

        // reset while waiting on a write to reg 3
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0C; bus.pwrite = 1'b1;
        bus.pwdata = 32'h77; wait_cycles = 4'd3;
        @(posedge clk); #1 bus.penable = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        chk("rst_mid_pready", {511'b0, bus.pready}, 512'd0);
        chk("rst_mid_prdata", {480'b0, bus.prdata}, 512'd0);
        chk("rst_mid_pslverr", {511'b0, bus.pslverr}, 512'd0);
        chk("rst_mid_wr_pulse", {496'b0, wr_pulse}, 512'd0);
        chk("rst_mid_proto_err", {511'b0, proto_err}, 512'd0);
        chk("rst_mid_reg_q", reg_q, 512'd0);

        xfer(32'h0C, 1'b1, 32'h66, 4'd0, 4'd0, rd, err, lat, pulse);
        chk("post_rst_w_latency", 512'(lat), 512'd2);
        chk("post_rst_w_pslverr", {511'b0, err}, 512'd0);
        chk("post_rst_w_pulse", {496'b0, pulse}, {496'b0, 16'h0008});
        xfer(32'h0C, 1'b0, 32'h0, 4'd0, 4'd0, rd, err, lat, pulse);
        chk("post_rst_r_prdata", {480'b0, rd}, {480'b0, 32'h66});
        chk("post_rst_reg3", {480'b0, reg_q[127:96]}, {480'b0, 32'h66});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
